vga_sync_ctrl: RTL
==================

VGA_SYNC_CTRL -- requirements
Module: vga_sync_ctrl

Interface
REQ-001 The block SHALL provide parameter H_ACTIVE, default 640, visible columns per line.
REQ-002 The block SHALL provide parameter H_FRONT, default 16, horizontal front-porch clocks.
REQ-003 The block SHALL provide parameter H_SYNC, default 96, horizontal sync-pulse clocks.
REQ-004 The block SHALL provide parameter H_BACK, default 48, horizontal back-porch clocks; line total = sum of the four H_* values (800).
REQ-005 The block SHALL provide parameters V_ACTIVE 480, V_FRONT 10, V_SYNC 2, V_BACK 33, the vertical equivalents in lines; frame total = 525.
REQ-006 The block SHALL have port clock, input, 1, pixel clock; the single clock domain.
REQ-007 The block SHALL have port reset_n, input, 1, reset, asynchronous, active-low.
REQ-008 The block SHALL have port enable, input, 1, run request; sampled only at frame boundaries.
REQ-009 The block SHALL have ports hsync and vsync, output, 1 each, active-low sync pulses.
REQ-010 The block SHALL have port active, output, 1, high while col < H_ACTIVE and row < V_ACTIVE.
REQ-011 The block SHALL have ports col and row, output, 10 each, current pixel position.
REQ-012 The block SHALL have ports line_start and frame_start, output, 1 each, single-cycle strobes.
REQ-013 The block SHALL have port running, output, 1, high when not in IDLE.

Function
REQ-014 The block SHALL implement a top-level FSM with states IDLE and RUN, and horizontal/vertical phase FSMs with states ACTIVE, FRONT, SYNC and BACK.
REQ-015 All outputs SHALL be registered and mutually consistent: hsync, vsync, active and the strobes SHALL describe the col/row value presented in the same cycle.
REQ-016 In RUN, col SHALL increment by 1 each clock and wrap from 799 to 0; row SHALL increment when col wraps and wrap from 524 to 0.
REQ-017 H phase SHALL be ACTIVE for col 0-639, FRONT for 640-655, SYNC for 656-751 (hsync=0) and BACK for 752-799.
REQ-018 V phase SHALL be ACTIVE for rows 0-479, FRONT for 480-489, SYNC for 490-491 (vsync=0 for the whole line) and BACK for 492-524.
REQ-019 line_start SHALL be 1 when col=0 in RUN; frame_start SHALL be 1 when col=0 and row=0 in RUN.
REQ-020 In IDLE: col=0, row=0, hsync=1, vsync=1, active=0, strobes=0, running=0.
REQ-021 IDLE to RUN SHALL occur when enable=1 is sampled in IDLE; the next cycle SHALL present col=0, row=0, active=1 and frame_start=1.
REQ-022 enable=0 during a frame SHALL NOT truncate it; the transition RUN to IDLE SHALL occur only on the cycle after col=799, row=524.
REQ-023 enable=1 sampled at col=799, row=524 SHALL continue into the next frame with no idle gap.
REQ-024 An enable pulse that deasserts before a frame boundary SHALL have no effect.

Reset
REQ-025 Assertion of reset_n=0 SHALL immediately force IDLE and the REQ-020 output values, including mid-frame and mid-sync-pulse.
REQ-026 After release, the block SHALL remain in IDLE until enable=1 is sampled on a rising clock edge.

Configuration
REQ-027 When macro VGA_FRAME_COUNT_EN is defined, the block SHALL add output frame_count, 8 bits, reset to 0, incremented on each frame_start and wrapping 255 to 0.
REQ-028 When VGA_FRAME_COUNT_EN is undefined, the frame_count port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-029 The bench SHALL cover: reset, enable=1 for 1 cycle -> next cycle col=0, row=0, active=1, frame_start=1; after 800 clocks, row=1 and line_start=1.
REQ-030 The bench SHALL cover: one full frame -> hsync=0 for exactly cols 656-751 of each line, vsync=0 for exactly 1600 clocks (rows 490-491), and active asserted 307200 clocks.
REQ-031 The bench SHALL cover: enable dropped at row=100 -> the frame completes to col=799, row=524, then running=0, hsync=vsync=1.
REQ-032 The bench SHALL cover: enable held high -> frame_start repeats every 420000 clocks with no gap.
REQ-033 The bench SHALL cover: reset_n asserted at col=700, row=490 -> outputs reach the IDLE values with no clock edge.
REQ-034 The bench SHALL cover, with VGA_FRAME_COUNT_EN defined: 257 frames -> frame_count=1.

Source files
------------

// File: rtl/vga_sync_ctrl.sv
// VGA sync controller: raster position counters, horizontal/vertical phase
// FSMs and registered sync/blanking outputs for a single pixel-clock domain.
// The run/idle decision is taken only at frame boundaries.
// Optional feature macro: VGA_FRAME_COUNT_EN adds an 8-bit frame_count output.
// Assumes every timing parameter is non-zero and both totals fit in 10 bits.
module vga_sync_ctrl #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FRONT  = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BACK   = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FRONT  = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BACK   = 33
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       enable,
  output logic       hsync,
  output logic       vsync,
  output logic       active,
  output logic [9:0] col,
  output logic [9:0] row,
  output logic       line_start,
  output logic       frame_start,
  output logic       running
`ifdef VGA_FRAME_COUNT_EN
  ,
  output logic [7:0] frame_count
`endif
);

  localparam int unsigned POS_W   = 10;
  localparam int unsigned H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

  // Phase boundaries expressed as the first position of each phase
  localparam logic [POS_W-1:0] H_LAST        = POS_W'(H_TOTAL - 1);
  localparam logic [POS_W-1:0] H_FRONT_START = POS_W'(H_ACTIVE);
  localparam logic [POS_W-1:0] H_SYNC_START  = POS_W'(H_ACTIVE + H_FRONT);
  localparam logic [POS_W-1:0] H_BACK_START  = POS_W'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [POS_W-1:0] V_LAST        = POS_W'(V_TOTAL - 1);
  localparam logic [POS_W-1:0] V_FRONT_START = POS_W'(V_ACTIVE);
  localparam logic [POS_W-1:0] V_SYNC_START  = POS_W'(V_ACTIVE + V_FRONT);
  localparam logic [POS_W-1:0] V_BACK_START  = POS_W'(V_ACTIVE + V_FRONT + V_SYNC);

  // Top-level states
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  // Horizontal / vertical phase states
  localparam logic [1:0] PH_ACTIVE = 2'd0;
  localparam logic [1:0] PH_FRONT  = 2'd1;
  localparam logic [1:0] PH_SYNC   = 2'd2;
  localparam logic [1:0] PH_BACK   = 2'd3;

  logic [0:0]       state, state_nxt;
  logic [1:0]       h_phase, h_phase_nxt;
  logic [1:0]       v_phase, v_phase_nxt;
  logic [POS_W-1:0] col_nxt, row_nxt;
  logic [POS_W-1:0] col_inc, row_inc;
  logic             line_end, frame_end;
  logic             run_nxt;
  logic             hsync_nxt, vsync_nxt, active_nxt;
  logic             line_start_nxt, frame_start_nxt;

  assign col_inc   = col + POS_W'(1);
  assign row_inc   = row + POS_W'(1);
  assign line_end  = (col == H_LAST);
  assign frame_end = line_end && (row == V_LAST);

  // Next state, next position, next phases and the output values that
  // will describe that next position
  always_comb begin
    state_nxt   = state;
    col_nxt     = col;
    row_nxt     = row;
    h_phase_nxt = h_phase;
    v_phase_nxt = v_phase;

    case (state)
      ST_IDLE: begin
        col_nxt     = '0;
        row_nxt     = '0;
        h_phase_nxt = PH_ACTIVE;
        v_phase_nxt = PH_ACTIVE;
        if (enable) begin
          state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (line_end) begin
          col_nxt     = '0;
          h_phase_nxt = PH_ACTIVE;
          if (frame_end) begin
            row_nxt     = '0;
            v_phase_nxt = PH_ACTIVE;
            if (!enable) begin
              state_nxt = ST_IDLE;
            end
          end else begin
            row_nxt = row_inc;
            case (v_phase)
              PH_ACTIVE: if (row_inc == V_FRONT_START) v_phase_nxt = PH_FRONT;
              PH_FRONT:  if (row_inc == V_SYNC_START)  v_phase_nxt = PH_SYNC;
              PH_SYNC:   if (row_inc == V_BACK_START)  v_phase_nxt = PH_BACK;
              default:   v_phase_nxt = v_phase;
            endcase
          end
        end else begin
          col_nxt = col_inc;
          case (h_phase)
            PH_ACTIVE: if (col_inc == H_FRONT_START) h_phase_nxt = PH_FRONT;
            PH_FRONT:  if (col_inc == H_SYNC_START)  h_phase_nxt = PH_SYNC;
            PH_SYNC:   if (col_inc == H_BACK_START)  h_phase_nxt = PH_BACK;
            default:   h_phase_nxt = h_phase;
          endcase
        end
      end
      default: begin
        state_nxt   = ST_IDLE;
        col_nxt     = '0;
        row_nxt     = '0;
        h_phase_nxt = PH_ACTIVE;
        v_phase_nxt = PH_ACTIVE;
      end
    endcase

    run_nxt         = (state_nxt == ST_RUN);
    hsync_nxt       = !(run_nxt && (h_phase_nxt == PH_SYNC));
    vsync_nxt       = !(run_nxt && (v_phase_nxt == PH_SYNC));
    active_nxt      = run_nxt && (h_phase_nxt == PH_ACTIVE) && (v_phase_nxt == PH_ACTIVE);
    line_start_nxt  = run_nxt && (col_nxt == '0);
    frame_start_nxt = line_start_nxt && (row_nxt == '0);
  end

  // State, position, phase and output registers; reset lands in the idle values
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      h_phase     <= PH_ACTIVE;
      v_phase     <= PH_ACTIVE;
      col         <= '0;
      row         <= '0;
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      active      <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      running     <= 1'b0;
    end else begin
      state       <= state_nxt;
      h_phase     <= h_phase_nxt;
      v_phase     <= v_phase_nxt;
      col         <= col_nxt;
      row         <= row_nxt;
      hsync       <= hsync_nxt;
      vsync       <= vsync_nxt;
      active      <= active_nxt;
      line_start  <= line_start_nxt;
      frame_start <= frame_start_nxt;
      running     <= run_nxt;
    end
  end

`ifdef VGA_FRAME_COUNT_EN
  // Frame counter steps together with the frame_start strobe it counts
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      frame_count <= 8'd0;
    end else if (frame_start_nxt) begin
      frame_count <= frame_count + 8'd1;
    end
  end
`endif

endmodule
